// File: rtl/rst_seq.sv
// Reset sequencer: holds N active-low reset outputs asserted for HOLD cycles
// after reset, then releases them in ascending index order with GAP cycles
// between releases. A soft-reset request re-runs the whole sequence.
`timescale 1ns/1ps

module rst_seq #(
  parameter int N    = 4,
  parameter int HOLD = 16,
  parameter int GAP  = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  output logic [N-1:0] rst_n_o,
  output logic         busy_o,
  output logic         done_o
);

  // Counter is sized for the longer of the two intervals so it never wraps.
  localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW    = $clog2(MAXHG + 1);
  localparam int IW    = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [N-1:0]    rst_n_reg, rst_n_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;

  // One-hot select of the domain addressed by idx; avoids a variable-width
  // part select on rst_n.
  logic [N-1:0]    rel_sel;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_sel
      assign rel_sel[gi] = (idx_reg == IW'(gi));
    end
  endgenerate

  // State register with asynchronous reset to the fully-asserted condition.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_ASSERT;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      rst_n_reg <= '0;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      rst_n_reg <= rst_n_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic; a soft-reset request overrides any release or done event.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    rst_n_next = rst_n_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    if (req_i) begin
      state_next = ST_ASSERT;
      cnt_next   = '0;
      idx_next   = '0;
      rst_n_next = '0;
      busy_next  = 1'b1;
    end else begin
      case (state_reg)
        ST_ASSERT: begin
          if (cnt_reg == CW'(HOLD - 1)) begin
            rst_n_next[0] = 1'b1;
            cnt_next      = '0;
            idx_next      = IW'(1);
            if (N == 1) begin
              state_next = ST_RUN;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end else begin
              state_next = ST_RELEASE;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_reg == CW'(GAP - 1)) begin
            rst_n_next = rst_n_reg | rel_sel;
            idx_next   = idx_reg + IW'(1);
            cnt_next   = '0;
            if (idx_reg == IW'(N - 1)) begin
              state_next = ST_RUN;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        ST_RUN: begin
          // All outputs hold; done drops after its single pulse cycle.
        end
        default: begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
          idx_next   = '0;
          rst_n_next = '0;
          busy_next  = 1'b1;
        end
      endcase
    end
  end

  assign rst_n_o = rst_n_reg;
  assign busy_o  = busy_reg;
  assign done_o  = done_reg;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: default instance (N=4, HOLD=16, GAP=8) plus a
// degenerate instance (N=1, HOLD=1, GAP=1).
`timescale 1ns/1ps

module tb_rst_seq;

  logic       clk;
  logic       rst;
  logic       req;
  logic [3:0] rst_n;
  logic       busy;
  logic       done;

  logic       rst1;
  logic       req1;
  logic [0:0] rst_n1;
  logic       busy1;
  logic       done1;

  int checks = 0;
  int errors = 0;

  rst_seq #(.N(4), .HOLD(16), .GAP(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .rst_n_o (rst_n),
    .busy_o  (busy),
    .done_o  (done)
  );

  rst_seq #(.N(1), .HOLD(1), .GAP(1)) dut1 (
    .clk_i   (clk),
    .rst_i   (rst1),
    .req_i   (req1),
    .rst_n_o (rst_n1),
    .busy_o  (busy1),
    .done_o  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed schedule: releases after edges 16, 24, 32, 40.
  function automatic logic [3:0] exp_rst(input int e);
    if (e < 16)      return 4'b0000;
    else if (e < 24) return 4'b0001;
    else if (e < 32) return 4'b0011;
    else if (e < 40) return 4'b0111;
    else             return 4'b1111;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rst_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got rst_n=%b busy=%b done=%b want 0000/1/0",
                 c, rst_n, busy, done);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 41; e++) begin
      @(posedge clk); #1;
      checks++;
      if (rst_n !== exp_rst(e) || busy !== (e < 40) || done !== (e == 40)) begin
        errors++;
        $display("FAIL powerup_seq edge %0d: got rst_n=%b busy=%b done=%b want %b/%b/%b",
                 e, rst_n, busy, done, exp_rst(e), (e < 40), (e == 40));
      end
    end
    $display("test_reset: power-up sequence complete");
  endtask

  task automatic test_soft_reset_run();
    req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rst_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL softreq_run_latency: got rst_n=%b busy=%b done=%b want 0000/1/0",
               rst_n, busy, done);
    end
    req = 1'b0;
    for (int e = 1; e <= 41; e++) begin
      @(posedge clk); #1;
      checks++;
      if (rst_n !== exp_rst(e) || busy !== (e < 40) || done !== (e == 40)) begin
        errors++;
        $display("FAIL softreq_run_seq edge %0d: got rst_n=%b busy=%b done=%b want %b/%b/%b",
                 e, rst_n, busy, done, exp_rst(e), (e < 40), (e == 40));
      end
    end
    $display("test_soft_reset_run: sequence complete");
  endtask

  task automatic test_soft_reset_release();
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      @(posedge clk); #1;
      checks++;
      if (rst_n !== exp_rst(e) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL midrel_prefix edge %0d: got rst_n=%b busy=%b want %b/1",
                 e, rst_n, busy, exp_rst(e));
      end
    end
    // Request lands on what would have been the third release edge.
    req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rst_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrel_abort: got rst_n=%b busy=%b done=%b want 0000/1/0",
               rst_n, busy, done);
    end
    req = 1'b0;
    for (int e = 1; e <= 41; e++) begin
      @(posedge clk); #1;
      checks++;
      if (rst_n !== exp_rst(e) || busy !== (e < 40) || done !== (e == 40)) begin
        errors++;
        $display("FAIL midrel_restart edge %0d: got rst_n=%b busy=%b done=%b want %b/%b/%b",
                 e, rst_n, busy, done, exp_rst(e), (e < 40), (e == 40));
      end
    end
    $display("test_soft_reset_release: restart complete");
  endtask

  task automatic test_held_req();
    req = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rst_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL held_req cyc %0d: got rst_n=%b busy=%b done=%b want 0000/1/0",
                 c, rst_n, busy, done);
      end
    end
    req = 1'b0;
    for (int e = 1; e <= 41; e++) begin
      @(posedge clk); #1;
      checks++;
      if (rst_n !== exp_rst(e) || busy !== (e < 40) || done !== (e == 40)) begin
        errors++;
        $display("FAIL held_req_seq edge %0d: got rst_n=%b busy=%b done=%b want %b/%b/%b",
                 e, rst_n, busy, done, exp_rst(e), (e < 40), (e == 40));
      end
    end
    $display("test_held_req: sequence complete");
  endtask

  task automatic test_async_abort();
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int e = 1; e <= 35; e++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (rst_n !== 4'b0111) begin
      errors++;
      $display("FAIL abort_precond: got rst_n=%b want 0111", rst_n);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rst_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: got rst_n=%b busy=%b done=%b want 0000/1/0",
               rst_n, busy, done);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 1; e <= 41; e++) begin
      @(posedge clk); #1;
      checks++;
      if (rst_n !== exp_rst(e) || busy !== (e < 40) || done !== (e == 40)) begin
        errors++;
        $display("FAIL abort_restart edge %0d: got rst_n=%b busy=%b done=%b want %b/%b/%b",
                 e, rst_n, busy, done, exp_rst(e), (e < 40), (e == 40));
      end
    end
    $display("test_async_abort: restart complete");
  endtask

  task automatic test_degenerate();
    checks++;
    if (rst_n1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL deg_reset: got rst_n=%b busy=%b done=%b want 0/1/0",
               rst_n1, busy1, done1);
    end
    // Request on the terminal-count edge suppresses release and done.
    rst1 = 1'b0;
    req1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rst_n1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL deg_req_priority: got rst_n=%b busy=%b done=%b want 0/1/0",
               rst_n1, busy1, done1);
    end
    req1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rst_n1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b1) begin
      errors++;
      $display("FAIL deg_release: got rst_n=%b busy=%b done=%b want 1/0/1",
               rst_n1, busy1, done1);
    end
    @(posedge clk); #1;
    checks++;
    if (rst_n1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL deg_run: got rst_n=%b busy=%b done=%b want 1/0/0",
               rst_n1, busy1, done1);
    end
    $display("test_degenerate: N=1 case complete");
  endtask

  initial begin
    rst  = 1'b1;
    req  = 1'b0;
    rst1 = 1'b1;
    req1 = 1'b0;
    test_reset();
    test_soft_reset_run();
    test_soft_reset_release();
    test_held_req();
    test_async_abort();
    test_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
